// File: rtl/filt_cicd_comp.sv
// ============================================================================
// filt_cicd_comp
// ----------------------------------------------------------------------------
// CIC droop-compensation FIR with optional output decimation. It sits directly
// after the CIC decimator. Every accepted sample shifts an N-deep delay line.
// Trigger samples start a computation on a single time-multiplexed MAC, which
// handles one tap per enabled cycle. The result is full precision and signed,
// with no rounding, truncation or saturation.
//
// Handshake: there is no backpressure. An input sample is taken on any edge
// where i_ena and i_valid are both high. o_valid is a one-cycle pulse that
// marks an update of o_data, and o_data holds its value between updates.
// o_overrun is a one-cycle pulse that marks an aborted computation.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst_an   asynchronous active-low reset
//   i_ena      global clock enable (all state frozen when low)
//   i_valid    input sample strobe
//   i_data     signed input sample   [gp_inp_width]
//   o_data     signed filter result  [gp_oup_width]
//   o_valid    result-updated pulse
//   o_overrun  computation-aborted pulse
// ============================================================================
module filt_cicd_comp #(
    parameter int gp_inp_width   = 14,
    parameter int gp_coeff_width = 8,
    parameter int gp_nr_taps     = 5,
    parameter logic [gp_nr_taps*gp_coeff_width-1:0] gp_coeffs =
        {8'sd1, 8'sd2, 8'sd3, 8'sd2, 8'sd1},
    parameter int gp_decimation_factor = 1,
    parameter int gp_phase             = 0,
    parameter int gp_oup_width = gp_inp_width + gp_coeff_width + $clog2(gp_nr_taps)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_an,
    input  logic                           i_ena,
    input  logic                           i_valid,
    input  logic signed [gp_inp_width-1:0] i_data,
    output logic signed [gp_oup_width-1:0] o_data,
    output logic                           o_valid,
    output logic                           o_overrun
);

    localparam int PROD_W = gp_inp_width + gp_coeff_width;
    localparam int KW     = $clog2(gp_nr_taps);
    localparam int PW     = (gp_decimation_factor > 1) ? $clog2(gp_decimation_factor) : 1;

    localparam logic [KW-1:0] K_LAST    = KW'(gp_nr_taps - 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(gp_decimation_factor - 1);
    localparam logic [PW-1:0] PH_TRIG   = PW'(gp_phase);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                          r_state;
    logic signed [gp_inp_width-1:0]  r_taps [gp_nr_taps];
    logic        [KW-1:0]            r_k;
    logic        [PW-1:0]            r_phase;
    logic signed [gp_oup_width-1:0]  r_acc;
    logic signed [gp_oup_width-1:0]  r_data;
    logic                            r_valid;
    logic                            r_overrun;

    logic signed [gp_coeff_width-1:0] w_coef [gp_nr_taps];
    logic signed [gp_inp_width-1:0]   w_x;
    logic signed [gp_coeff_width-1:0] w_c;
    logic signed [PROD_W-1:0]         w_prod;
    logic signed [gp_oup_width-1:0]   w_prod_ext;
    logic                             w_trigger;

    // Coefficient k lives at slice k of the flat vector and weights x[n-k].
    for (genvar g = 0; g < gp_nr_taps; g++) begin : g_coef
        assign w_coef[g] = gp_coeffs[(g+1)*gp_coeff_width-1 -: gp_coeff_width];
    end

    // Single shared multiplier. The tap counter selects both the operand and
    // the coefficient.
    assign w_x        = r_taps[r_k];
    assign w_c        = w_coef[r_k];
    assign w_prod     = w_x * w_c;
    assign w_prod_ext = gp_oup_width'(w_prod);

    // The trigger test uses the phase counter value from before it advances.
    assign w_trigger = (r_phase == PH_TRIG);

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            r_state   <= S_IDLE;
            for (int i = 0; i < gp_nr_taps; i++) r_taps[i] <= '0;
            r_k       <= '0;
            r_phase   <= '0;
            r_acc     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (!i_ena) begin
            // Frozen: only the pulse outputs are dropped.
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            if (i_valid) begin
                r_taps[0] <= i_data;
                for (int i = 1; i < gp_nr_taps; i++) r_taps[i] <= r_taps[i-1];
                r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
                // A sample that lands in MAC or DONE kills the in-flight result.
                // This includes the edge where DONE would complete.
                if (r_state != S_IDLE) r_overrun <= 1'b1;
                if (w_trigger) begin
                    r_state <= S_MAC;
                    r_acc   <= '0;
                    r_k     <= '0;
                end else begin
                    r_state <= S_IDLE;
                end
            end else begin
                case (r_state)
                    S_MAC: begin
                        r_acc <= r_acc + w_prod_ext;
                        if (r_k == K_LAST) begin
                            r_k     <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_data  <= r_acc;
                        r_valid <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid & i_ena;
    assign o_overrun = r_overrun & i_ena;

endmodule
